lsu_req_queue: RTL and testbench



---
 rtl/super_pkg.sv | 28 ++
 rtl/lsu_req_queue_fifo.sv | 63 ++++++
 rtl/lsu_req_queue.sv | 80 ++++++++
 tb/tb_lsu_req_queue.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/super_pkg.sv
// Shared LSU request types and the cacheability helper used by the request queue
// and the data cache.
package super_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        is_store;
    logic [1:0]  size;
    logic        rf_we;
    logic [4:0]  rd;
    logic        is_cap;
    logic        cache_ok;
  } lsu_req_info_t;

  localparam lsu_req_info_t NULL_LSU_REQ_INFO = '0;

  localparam logic [31:0] CACHE_BASE_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] CACHE_MASK_DEFAULT = 32'hF000_0000;

  // Capability accesses always bypass the cache.
  function automatic logic lsu_cacheable(input logic [31:0] addr,
                                         input logic        is_cap,
                                         input logic [31:0] base = CACHE_BASE_DEFAULT,
                                         input logic [31:0] mask = CACHE_MASK_DEFAULT);
    return ((addr & mask) == base) & ~is_cap;
  endfunction

endpackage

// File: rtl/lsu_req_queue_fifo.sv
// Synchronous FIFO with a single-cycle flush; head data is read straight from storage.
module sync_fifo_flush #(
  parameter int unsigned Depth = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  T     wdata_i,
  output logic full_o,
  output logic empty_o,
  output T     rdata_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  T                r_mem [Depth];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [CntW-1:0] r_cnt;

  logic w_push;
  logic w_pop;

  assign w_push = push_i & (r_cnt != DepthC);
  assign w_pop  = pop_i & (r_cnt != '0);

  // Storage resets to all-zero so the head reads as a null entry out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mem    <= '{default: '0};
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata_i;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign full_o  = (r_cnt == DepthC);
  assign empty_o = (r_cnt == '0);
  assign rdata_o = r_mem[r_rd_ptr];

endmodule

// File: rtl/lsu_req_queue.sv
// In-order LSU request queue: tags cacheability on entry and throttles issue on
// the number of bus responses still outstanding.
module lsu_req_queue
  import super_pkg::*;
#(
  parameter int unsigned Depth     = 4,
  parameter int unsigned MaxOutst  = 2,
  parameter logic [31:0] CacheBase = 32'h8000_0000,
  parameter logic [31:0] CacheMask = 32'hF000_0000,
  localparam int unsigned OutstW   = $clog2(MaxOutst + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              us_valid_i,
  input  lsu_req_info_t     lsu_req_dec_i,
  output logic              lspl_rdy_o,
  output logic              lsu_req_o,
  output lsu_req_info_t     lsu_req_info_o,
  input  logic              lsu_req_done_i,
  input  logic              lsu_resp_valid_i,
  output logic [OutstW-1:0] outst_cnt_o,
  output logic              idle_o
);

  localparam logic [OutstW-1:0] MaxOutstC = OutstW'(MaxOutst);

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_resp_dec;
  lsu_req_info_t     w_tagged;
  logic [OutstW-1:0] r_outst;

  always_comb begin
    w_tagged          = lsu_req_dec_i;
    w_tagged.cache_ok = lsu_cacheable(lsu_req_dec_i.addr, lsu_req_dec_i.is_cap,
                                      CacheBase, CacheMask);
  end

  // Ready and issue depend on registered state only: no path from done to ready.
  assign lspl_rdy_o = ~w_full;
  assign lsu_req_o  = ~w_empty & (r_outst < MaxOutstC);
  assign w_push     = us_valid_i & lspl_rdy_o & ~flush_i;
  assign w_pop      = lsu_req_o & lsu_req_done_i;
  assign w_resp_dec = lsu_resp_valid_i & (r_outst != '0);

  sync_fifo_flush #(
    .Depth (Depth),
    .T     (lsu_req_info_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (flush_i),
    .wdata_i (w_tagged),
    .full_o  (w_full),
    .empty_o (w_empty),
    .rdata_o (lsu_req_info_o)
  );

  // Flush leaves this alone so in-flight responses drain normally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outst <= '0;
    end else begin
      case ({w_pop, w_resp_dec})
        2'b10:   r_outst <= r_outst + OutstW'(1);
        2'b01:   r_outst <= r_outst - OutstW'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  assign outst_cnt_o = r_outst;
  assign idle_o      = w_empty & (r_outst == '0);

endmodule

// File: tb/tb_lsu_req_queue.sv
// Directed and randomized bench for lsu_req_queue against a queue-based reference model.
module tb_lsu_req_queue;
  import super_pkg::*;

  localparam int unsigned Depth    = 4;
  localparam int unsigned MaxOutst = 2;
  localparam int unsigned OutstW   = $clog2(MaxOutst + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              us_valid;
  lsu_req_info_t     dec;
  logic              rdy;
  logic              req;
  lsu_req_info_t     info;
  logic              done;
  logic              resp;
  logic [OutstW-1:0] outst;
  logic              idle;

  always #5 clk = ~clk;

  lsu_req_queue #(
    .Depth     (Depth),
    .MaxOutst  (MaxOutst),
    .CacheBase (32'h8000_0000),
    .CacheMask (32'hF000_0000)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .us_valid_i       (us_valid),
    .lsu_req_dec_i    (dec),
    .lspl_rdy_o       (rdy),
    .lsu_req_o        (req),
    .lsu_req_info_o   (info),
    .lsu_req_done_i   (done),
    .lsu_resp_valid_i (resp),
    .outst_cnt_o      (outst),
    .idle_o           (idle)
  );

  int errors = 0;
  int checks = 0;

  lsu_req_info_t mq[$];
  int            m_outst = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cacheable window is the 256 MiB region at 0x8000_0000, never for capabilities.
  function automatic lsu_req_info_t tag_req(input lsu_req_info_t r);
    lsu_req_info_t t;
    t          = r;
    t.cache_ok = (r.addr >= 32'h8000_0000) && (r.addr <= 32'h8FFF_FFFF) && !r.is_cap;
    return t;
  endfunction

  function automatic lsu_req_info_t mk(input logic [31:0] a, input logic cap, input logic we);
    lsu_req_info_t r;
    r          = '0;
    r.addr     = a;
    r.is_cap   = cap;
    r.rf_we    = we;
    r.is_store = 1'($urandom_range(0, 1));
    r.size     = 2'($urandom_range(0, 3));
    r.rd       = 5'($urandom_range(0, 31));
    r.cache_ok = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic compare_outputs();
    check("rdy", 64'(rdy), 64'(mq.size() < Depth));
    check("req", 64'(req), 64'((mq.size() > 0) && (m_outst < MaxOutst)));
    check("outst", 64'(outst), 64'(m_outst));
    check("idle", 64'(idle), 64'((mq.size() == 0) && (m_outst == 0)));
    if (mq.size() > 0) check("head", 64'(info), 64'(mq[0]));
  endtask

  // Checks the state left by the previous cycle, then applies one cycle of inputs.
  task automatic step(input logic r, input logic f, input logic v, input logic d,
                      input logic s, input lsu_req_info_t x);
    bit m_req;
    bit m_pop;
    bit m_push;
    @(negedge clk);
    compare_outputs();
    rst      = r;
    flush    = f;
    us_valid = v;
    done     = d;
    resp     = s;
    dec      = x;
    if (r) begin
      mq.delete();
      m_outst = 0;
    end else begin
      m_req  = (mq.size() > 0) && (m_outst < MaxOutst);
      m_pop  = m_req && d;
      m_push = v && (mq.size() < Depth) && !f;
      m_outst = m_outst + (m_pop ? 1 : 0) - ((s && m_outst > 0) ? 1 : 0);
      if (m_pop) void'(mq.pop_front());
      if (f) mq.delete();
      if (m_push) mq.push_back(tag_req(x));
    end
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(32'h0, 1'b0, 1'b0));
  endtask

  task automatic push(input logic [31:0] a, input logic cap);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(a, cap, 1'b1));
  endtask

  initial begin
    lsu_req_info_t  x;
    logic [31:0]    a;
    rst      = 1'b1;
    flush    = 1'b0;
    us_valid = 1'b0;
    done     = 1'b0;
    resp     = 1'b0;
    dec      = '0;
    repeat (2) @(negedge clk);
    check("reset_info", 64'(info), 64'(NULL_LSU_REQ_INFO));

    // Single push, issue, response.
    push(32'h8000_0010, 1'b0);
    idle_cycle();
    check("first_cache_ok", 64'(info.cache_ok), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(32'h0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(32'h0, 1'b0, 1'b0));
    idle_cycle();

    // Fill, overfill attempt, then done+push through wrap-around.
    for (int i = 0; i < 5; i++) push(32'h8000_0100 + 32'(i * 4), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, mk(32'h1000_0000 + 32'(i), 1'b0, 1'b1));
    end
    // Throttle at MaxOutst, then release with a response.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(32'h0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(32'h0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(32'h0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(32'h0, 1'b0, 1'b0));
    idle_cycle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(32'h0, 1'b0, 1'b0));
    repeat (6) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, mk(32'h0, 1'b0, 1'b0));
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(32'h0, 1'b0, 1'b0));

    // Flush with three queued, one outstanding, and a same-cycle push.
    push(32'h8000_0200, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(32'h2000_0000, 1'b0, 1'b1));
    push(32'h8000_0000, 1'b1);
    push(32'h8000_0300, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(32'h8000_0400, 1'b0, 1'b1));
    idle_cycle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(32'h0, 1'b0, 1'b0));
    // Spurious responses at zero outstanding.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(32'h0, 1'b0, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, mk(32'h0, 1'b0, 1'b0));

    // Tagging corner cases.
    push(32'h2000_0000, 1'b0);
    idle_cycle();
    check("noncache_addr", 64'(info.cache_ok), 64'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h0, 1'b0, 1'b0));
    push(32'h8000_0000, 1'b1);
    idle_cycle();
    check("cap_not_cacheable", 64'(info.cache_ok), 64'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h0, 1'b0, 1'b0));

    // Randomized traffic including occasional flush and mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      a = $urandom();
      if ($urandom_range(0, 1) == 0) a[31:28] = 4'h8;
      x = mk(a, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 2) == 0), x);
    end
    @(negedge clk);
    compare_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
